scaler_setup_seq: RTL and testbench

- Configuration sequencer for the horizontal and vertical fractional-interpolation scaler channels in the scandoubler/scaler path.
- Detects a video-mode change (new input active size) or an explicit start request.
- Programs each channel in turn: H first, then V. For each channel it drives num/den/limit, pulses newfraction, and waits for that channel's ready pulse.
- Then derives the centring offsets from the channels' anticipated output sizes and signals when the configuration is valid.

---
 rtl/scaler_pkg.sv | 25 ++
 rtl/scaler_chan_req.sv | 91 +++++++++
 rtl/scaler_setup_seq.sv | 159 +++++++++++++++
 tb/tb_scaler_setup_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// scaler_pkg: shared state encoding, default width and centring helper
// for the scaler setup sequencer.
package scaler_pkg;
  localparam int SCL_BW = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H_REQ,
    S_H_WAIT,
    S_V_REQ,
    S_V_WAIT,
    S_CENTRE,
    S_DONE
  } seq_state_e;

  // Half of (tgt - act), clamped to zero when the channel overshoots.
  function automatic logic [31:0] centre_off(
    input logic [31:0] tgt,
    input logic [31:0] act
  );
    logic [31:0] d;
    d = (tgt > act) ? (tgt - act) : 32'd0;
    return d >> 1;
  endfunction
endpackage

// File: rtl/scaler_chan_req.sv
// scaler_chan_req: one scaler channel's ratio registers, configure pulse,
// ready capture and validity check. SCALER_SETUP_TIMEOUT_EN adds a wait timeout.
module scaler_chan_req
  import scaler_pkg::*;
#(
  parameter int BITWIDTH = SCL_BW
`ifdef SCALER_SETUP_TIMEOUT_EN
  , parameter int TIMEOUT = 1023
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic                i_wait,
  input  logic [BITWIDTH-1:0] i_num,
  input  logic [BITWIDTH-1:0] i_den,
  input  logic                i_ready,
  input  logic [BITWIDTH-1:0] i_limit_out,
  output logic [BITWIDTH-1:0] o_num,
  output logic [BITWIDTH-1:0] o_den,
  output logic [BITWIDTH-1:0] o_limit,
  output logic                o_nf,
  output logic                o_bad,
  output logic                o_done,
  output logic                o_to,
  output logic                o_fail,
  output logic [BITWIDTH-1:0] o_cap
);
  logic [BITWIDTH-1:0] r_num, r_den, r_lim, r_cap;
  logic                r_nf, r_fail;
  logic                w_bad, w_hit, w_to;

  assign w_bad = i_req && ((i_den == '0) || (i_den > i_num));
  // Ready coinciding with our own configure pulse is stale.
  assign w_hit = i_wait && i_ready && !r_nf;

`ifdef SCALER_SETUP_TIMEOUT_EN
  logic [BITWIDTH-1:0] r_cnt;

  assign w_to = i_wait && !w_hit
             && (r_cnt == BITWIDTH'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_req) begin
      r_cnt <= '0;
    end else if (i_wait) begin
      r_cnt <= r_cnt + BITWIDTH'(1);
    end
  end
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num  <= '0;
      r_den  <= '0;
      r_lim  <= '0;
      r_cap  <= '0;
      r_nf   <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_nf <= i_req && !w_bad;
      if (i_req && !w_bad) begin
        r_num <= i_num;
        r_den <= i_den;
        r_lim <= i_den;
      end
      if (w_hit) begin
        r_cap <= i_limit_out;
      end
      if (i_req) begin
        r_fail <= w_bad;
      end else if (w_to) begin
        r_fail <= 1'b1;
      end
    end
  end

  assign o_num   = r_num;
  assign o_den   = r_den;
  assign o_limit = r_lim;
  assign o_nf    = r_nf;
  assign o_bad   = w_bad;
  assign o_done  = w_hit || w_to;
  assign o_to    = w_to;
  assign o_fail  = r_fail;
  assign o_cap   = r_cap;
endmodule

// File: rtl/scaler_setup_seq.sv
// scaler_setup_seq: programs H then V scaler channels and derives centring.
// Optional wait timeout enabled by SCALER_SETUP_TIMEOUT_EN.
module scaler_setup_seq
  import scaler_pkg::*;
#(
  parameter int BITWIDTH = SCL_BW
`ifdef SCALER_SETUP_TIMEOUT_EN
  , parameter int TIMEOUT = 1023
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [BITWIDTH-1:0] in_w,
  input  logic [BITWIDTH-1:0] in_h,
  input  logic [BITWIDTH-1:0] out_w,
  input  logic [BITWIDTH-1:0] out_h,
  output logic [BITWIDTH-1:0] h_num,
  output logic [BITWIDTH-1:0] h_den,
  output logic [BITWIDTH-1:0] h_limit,
  output logic [BITWIDTH-1:0] v_num,
  output logic [BITWIDTH-1:0] v_den,
  output logic [BITWIDTH-1:0] v_limit,
  output logic                h_newfraction,
  output logic                v_newfraction,
  input  logic                h_ready,
  input  logic                v_ready,
  input  logic [BITWIDTH-1:0] h_limit_out,
  input  logic [BITWIDTH-1:0] v_limit_out,
  output logic [BITWIDTH-1:0] h_centre_offset,
  output logic [BITWIDTH-1:0] v_centre_offset,
  output logic                busy,
  output logic                cfg_valid,
  output logic                err
);
  seq_state_e          r_state, w_next;
  logic [BITWIDTH-1:0] r_in_w, r_in_h, r_hoff, r_voff;
  logic                r_pend, r_busy, r_valid, r_err;
  logic                w_mode, w_trig, w_rest;
  logic                w_h_bad, w_h_done, w_h_to, w_h_fail;
  logic                w_v_bad, w_v_done, w_v_to, w_v_fail;
  logic [BITWIDTH-1:0] w_h_cap, w_v_cap, w_h_off, w_v_off;

  scaler_chan_req #(
    .BITWIDTH(BITWIDTH)
`ifdef SCALER_SETUP_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) u_h (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_req       (r_state == S_H_REQ),
    .i_wait      (r_state == S_H_WAIT),
    .i_num       (out_w),
    .i_den       (in_w),
    .i_ready     (h_ready),
    .i_limit_out (h_limit_out),
    .o_num       (h_num),
    .o_den       (h_den),
    .o_limit     (h_limit),
    .o_nf        (h_newfraction),
    .o_bad       (w_h_bad),
    .o_done      (w_h_done),
    .o_to        (w_h_to),
    .o_fail      (w_h_fail),
    .o_cap       (w_h_cap)
  );

  scaler_chan_req #(
    .BITWIDTH(BITWIDTH)
`ifdef SCALER_SETUP_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) u_v (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_req       (r_state == S_V_REQ),
    .i_wait      (r_state == S_V_WAIT),
    .i_num       (out_h),
    .i_den       (r_in_h),
    .i_ready     (v_ready),
    .i_limit_out (v_limit_out),
    .o_num       (v_num),
    .o_den       (v_den),
    .o_limit     (v_limit),
    .o_nf        (v_newfraction),
    .o_bad       (w_v_bad),
    .o_done      (w_v_done),
    .o_to        (w_v_to),
    .o_fail      (w_v_fail),
    .o_cap       (w_v_cap)
  );

  // H_REQ is latching the new mode, so a size difference there is not news.
  assign w_mode = (in_w != r_in_w) || (in_h != r_in_h);
  assign w_trig = start || (w_mode && (r_state != S_H_REQ));
  assign w_rest = (r_state == S_IDLE) || (r_state == S_DONE);

  assign w_h_off = BITWIDTH'(centre_off(32'(out_w), 32'(w_h_cap)));
  assign w_v_off = BITWIDTH'(centre_off(32'(out_h), 32'(w_v_cap)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_trig) w_next = S_H_REQ;
      S_H_REQ:  w_next = w_h_bad ? S_V_REQ : S_H_WAIT;
      S_H_WAIT: if (w_h_done) w_next = S_V_REQ;
      S_V_REQ:  w_next = w_v_bad ? S_CENTRE : S_V_WAIT;
      S_V_WAIT: if (w_v_done) w_next = S_CENTRE;
      S_CENTRE: w_next = S_DONE;
      S_DONE:   if (r_pend || w_trig) w_next = S_H_REQ;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_w  <= '0;
      r_in_h  <= '0;
      r_hoff  <= '0;
      r_voff  <= '0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_pend <= w_rest ? 1'b0 : (r_pend || w_trig);
      if (r_state == S_H_REQ) begin
        r_in_w  <= in_w;
        r_in_h  <= in_h;
        r_busy  <= 1'b1;
        r_valid <= 1'b0;
        r_err   <= w_h_bad;
      end else begin
        r_err <= r_err || w_v_bad || w_h_to || w_v_to;
      end
      if (r_state == S_CENTRE) begin
        r_busy  <= 1'b0;
        r_valid <= !r_err;
        r_hoff  <= w_h_fail ? '0 : w_h_off;
        r_voff  <= w_v_fail ? '0 : w_v_off;
      end
    end
  end

  assign h_centre_offset = r_hoff;
  assign v_centre_offset = r_voff;
  assign busy            = r_busy;
  assign cfg_valid       = r_valid;
  assign err             = r_err;
endmodule

// File: tb/tb_scaler_setup_seq.sv
// tb_scaler_setup_seq: directed and randomized runs against a
// transaction-level model of the setup sequence, with stub channels.
module tb_scaler_setup_seq;
  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          reset_n, start;
  logic [BW-1:0] in_w, in_h, out_w, out_h;
  logic [BW-1:0] h_num, h_den, h_limit, v_num, v_den, v_limit;
  logic          h_newfraction, v_newfraction;
  logic          h_ready, v_ready;
  logic [BW-1:0] h_limit_out, v_limit_out;
  logic [BW-1:0] h_centre_offset, v_centre_offset;
  logic          busy, cfg_valid, err;

  int n_chk = 0;
  int n_err = 0;
  int h_nf_cnt = 0;
  int v_nf_cnt = 0;

  logic          h_auto, v_auto;
  logic [BW-1:0] h_resp, v_resp;
  int            h_dly, v_dly;

  int e_hnum, e_hden, e_hlim, e_vnum, e_vden, e_vlim;

  scaler_setup_seq dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .in_w            (in_w),
    .in_h            (in_h),
    .out_w           (out_w),
    .out_h           (out_h),
    .h_num           (h_num),
    .h_den           (h_den),
    .h_limit         (h_limit),
    .v_num           (v_num),
    .v_den           (v_den),
    .v_limit         (v_limit),
    .h_newfraction   (h_newfraction),
    .v_newfraction   (v_newfraction),
    .h_ready         (h_ready),
    .v_ready         (v_ready),
    .h_limit_out     (h_limit_out),
    .v_limit_out     (v_limit_out),
    .h_centre_offset (h_centre_offset),
    .v_centre_offset (v_centre_offset),
    .busy            (busy),
    .cfg_valid       (cfg_valid),
    .err             (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (h_newfraction) h_nf_cnt++;
    if (v_newfraction) v_nf_cnt++;
  end

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic cur(input int sel);
    case (sel)
      0:       return busy;
      1:       return cfg_valid;
      2:       return v_newfraction;
      default: return h_newfraction;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input string tag);
    int got;
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cur(sel) == val) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check(tag, got, 1);
  endtask

  // Stub channels: a stale ready in the configure cycle, then the real one.
  initial begin
    h_ready = 1'b0;
    h_limit_out = '0;
    forever begin
      @(negedge clk);
      if (h_newfraction && h_auto) begin
        h_ready = 1'b1;
        h_limit_out = 10'h3ff;
        @(negedge clk);
        h_ready = 1'b0;
        repeat (h_dly) @(negedge clk);
        h_ready = 1'b1;
        h_limit_out = h_resp;
        @(negedge clk);
        h_ready = 1'b0;
      end
    end
  end

  initial begin
    v_ready = 1'b0;
    v_limit_out = '0;
    forever begin
      @(negedge clk);
      if (v_newfraction && v_auto) begin
        v_ready = 1'b1;
        v_limit_out = 10'h3ff;
        @(negedge clk);
        v_ready = 1'b0;
        repeat (v_dly) @(negedge clk);
        v_ready = 1'b1;
        v_limit_out = v_resp;
        @(negedge clk);
        v_ready = 1'b0;
      end
    end
  end

  function automatic int half_gap(input int tgt, input int act);
    return (tgt > act) ? (tgt - act) / 2 : 0;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_hnum"}, int'(h_num), e_hnum);
    check({tag, "_hden"}, int'(h_den), e_hden);
    check({tag, "_hlim"}, int'(h_limit), e_hlim);
    check({tag, "_vnum"}, int'(v_num), e_vnum);
    check({tag, "_vden"}, int'(v_den), e_vden);
    check({tag, "_vlim"}, int'(v_limit), e_vlim);
  endtask

  task automatic run_cfg(input int iw, input int ih, input int ow,
                         input int oh, input int hl, input int vl,
                         input string tag);
    int hb, vb, h0, v0;
    hb = (iw == 0 || iw > ow) ? 1 : 0;
    vb = (ih == 0 || ih > oh) ? 1 : 0;
    in_w = BW'(iw);
    in_h = BW'(ih);
    out_w = BW'(ow);
    out_h = BW'(oh);
    h_resp = BW'(hl);
    v_resp = BW'(vl);
    h_dly = int'($urandom_range(0, 4));
    v_dly = int'($urandom_range(0, 4));
    h0 = h_nf_cnt;
    v0 = v_nf_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(0, 1'b1, {tag, "_busy_on"});
    wait_for(0, 1'b0, {tag, "_busy_off"});
    if (hb == 0) begin
      e_hnum = ow;
      e_hden = iw;
      e_hlim = iw;
    end
    if (vb == 0) begin
      e_vnum = oh;
      e_vden = ih;
      e_vlim = ih;
    end
    check_regs(tag);
    check({tag, "_hoff"}, int'(h_centre_offset), hb ? 0 : half_gap(ow, hl));
    check({tag, "_voff"}, int'(v_centre_offset), vb ? 0 : half_gap(oh, vl));
    check({tag, "_err"}, int'(err), (hb | vb));
    check({tag, "_valid"}, int'(cfg_valid), (hb | vb) ? 0 : 1);
    check({tag, "_hnf"}, h_nf_cnt - h0, 1 - hb);
    check({tag, "_vnf"}, v_nf_cnt - v0, 1 - vb);
  endtask

  initial begin
    int h0, ow, oh, iw, ih;
    reset_n = 1'b0;
    start = 1'b0;
    in_w = '0;
    in_h = '0;
    out_w = '0;
    out_h = '0;
    h_auto = 1'b1;
    v_auto = 1'b1;
    h_resp = '0;
    v_resp = '0;
    h_dly = 0;
    v_dly = 0;
    e_hnum = 0; e_hden = 0; e_hlim = 0;
    e_vnum = 0; e_vden = 0; e_vlim = 0;

    repeat (3) @(negedge clk);
    check_regs("rst");
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(cfg_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_hoff", int'(h_centre_offset), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cfg(320, 240, 640, 480, 640, 480, "basic");
    run_cfg(256, 224, 640, 480, 600, 479, "centre");

    // Mode change during V_WAIT: finish, show valid, rerun once.
    in_w = 10'd320;
    in_h = 10'd240;
    h_resp = 10'd640;
    v_resp = 10'd480;
    h_dly = 2;
    v_dly = 6;
    h0 = h_nf_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(2, 1'b1, "pend_vnf");
    in_w = 10'd256;
    wait_for(1, 1'b1, "pend_valid");
    check("pend_hden1", int'(h_den), 320);
    wait_for(0, 1'b1, "pend_busy2");
    wait_for(0, 1'b0, "pend_idle2");
    check("pend_hden2", int'(h_den), 256);
    check("pend_valid2", int'(cfg_valid), 1);
    check("pend_hnf", h_nf_cnt - h0, 2);
    e_hnum = 640; e_hden = 256; e_hlim = 256;
    e_vnum = 480; e_vden = 240; e_vlim = 240;

    run_cfg(800, 240, 640, 480, 600, 470, "down");

    // Reset while H_WAIT is stalled on ready.
    h_auto = 1'b0;
    in_w = 10'd320;
    in_h = 10'd240;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(3, 1'b1, "arst_hnf");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_hnum", int'(h_num), 0);
    check("arst_vnum", int'(v_num), 0);
    check("arst_err", int'(err), 0);
    check("arst_valid", int'(cfg_valid), 0);
    in_w = '0;
    in_h = '0;
    @(negedge clk);
    reset_n = 1'b1;
    h0 = h_nf_cnt;
    repeat (10) @(negedge clk);
    check("arst_quiet", h_nf_cnt - h0, 0);
    check("arst_idle", int'(busy), 0);
    e_hnum = 0; e_hden = 0; e_hlim = 0;
    e_vnum = 0; e_vden = 0; e_vlim = 0;
    h_auto = 1'b1;

    for (int k = 0; k < 24; k++) begin
      ow = int'($urandom_range(16, 1023));
      oh = int'($urandom_range(16, 1023));
      iw = int'($urandom_range(1, ow));
      ih = int'($urandom_range(1, oh));
      if ($urandom_range(0, 5) == 0) begin
        iw = (ow < 1023) ? int'($urandom_range(ow + 1, 1023)) : 0;
      end
      if ($urandom_range(0, 5) == 0) begin
        ih = (oh < 1023 && $urandom_range(0, 1) == 1)
           ? int'($urandom_range(oh + 1, 1023)) : 0;
      end
      run_cfg(iw, ih, ow, oh,
              int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)), "rnd");
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
